// File: rtl/variable_tick_gen_if.sv
// Control/status bundle between the game controller and the variable tick generator.
interface variable_tick_gen_if #(
    parameter int SPEED_W  = 4,
    parameter int PERIOD_W = 16,
    parameter int CNT_W    = 8
);
    logic                enable;
    logic                restart;
    logic                one_shot;
    logic [SPEED_W-1:0]  speed;
    logic                time_out;
    logic                done;
    logic [PERIOD_W-1:0] period_cur;
    logic [CNT_W-1:0]    tick_count;

    modport master (
        output enable, restart, one_shot, speed,
        input  time_out, done, period_cur, tick_count
    );

    modport slave (
        input  enable, restart, one_shot, speed,
        output time_out, done, period_cur, tick_count
    );
endinterface

// File: rtl/variable_tick_gen.sv
// Prescaled, speed-selectable period timer with pause, one-shot and wrapping event count.
// Base ticks come from a clock prescaler; a period counter divides them by a speed-derived period.
module variable_tick_gen #(
    parameter int PRESCALE    = 50000,
    parameter int BASE_PERIOD = 1000,
    parameter int STEP        = 50,
    parameter int MIN_PERIOD  = 100,
    parameter int SPEED_W     = 4,
    parameter int PERIOD_W    = 16,
    parameter int CNT_W       = 8
) (
    input  logic                clock,
    input  logic                reset,
    variable_tick_gen_if.slave  bus
);

    localparam int PRE_W  = $clog2(PRESCALE);
    localparam int PROD_W = PERIOD_W + SPEED_W;

    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0]    PRE_ONE   = PRE_W'(1);
    localparam logic [PROD_W-1:0]   SLACK     = PROD_W'(BASE_PERIOD - MIN_PERIOD);
    localparam logic [PROD_W-1:0]   BASE_WIDE = PROD_W'(BASE_PERIOD);
    localparam logic [PERIOD_W-1:0] PER_BASE  = PERIOD_W'(BASE_PERIOD);
    localparam logic [PERIOD_W-1:0] PER_MIN   = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] PER_ONE   = PERIOD_W'(1);
    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    state_e              state_q,      state_d;
    logic [PRE_W-1:0]    pre_cnt_q,    pre_cnt_d;
    logic [PERIOD_W-1:0] per_cnt_q,    per_cnt_d;
    logic [PERIOD_W-1:0] period_q,     period_d;
    logic                time_out_q,   time_out_d;
    logic                done_q,       done_d;
    logic [CNT_W-1:0]    tick_count_q, tick_count_d;

    logic [PROD_W-1:0]   prod_s;
    logic [PERIOD_W-1:0] calc_s;

    // Speed-to-period mapping; the product is kept wide so large speeds clamp instead of wrapping.
    always_comb begin
        prod_s = PROD_W'(bus.speed) * PROD_W'(STEP);
        if (prod_s > SLACK) begin
            calc_s = PER_MIN;
        end else begin
            calc_s = PERIOD_W'(BASE_WIDE - prod_s);
        end
    end

    // Next-state and counter logic; restart overrides everything, including a coincident terminal count.
    always_comb begin
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        per_cnt_d    = per_cnt_q;
        period_d     = period_q;
        time_out_d   = 1'b0;
        done_d       = done_q;
        tick_count_d = tick_count_q;

        if (bus.restart) begin
            state_d   = ST_RUN;
            pre_cnt_d = '0;
            per_cnt_d = '0;
            period_d  = calc_s;
            done_d    = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.enable) begin
                        if (pre_cnt_q == PRE_LAST) begin
                            pre_cnt_d = '0;
                            if (per_cnt_q == (period_q - PER_ONE)) begin
                                per_cnt_d    = '0;
                                time_out_d   = 1'b1;
                                tick_count_d = tick_count_q + CNT_ONE;
                                // New speed is only picked up here, on the period boundary.
                                period_d     = calc_s;
                                if (bus.one_shot) begin
                                    state_d = ST_DONE;
                                    done_d  = 1'b1;
                                end else begin
                                    state_d = ST_RUN;
                                    done_d  = 1'b0;
                                end
                            end else begin
                                per_cnt_d = per_cnt_q + PER_ONE;
                            end
                        end else begin
                            pre_cnt_d = pre_cnt_q + PRE_ONE;
                        end
                    end else begin
                        pre_cnt_d = pre_cnt_q;
                        per_cnt_d = per_cnt_q;
                    end
                end
                ST_DONE: begin
                    pre_cnt_d = '0;
                    per_cnt_d = '0;
                    done_d    = 1'b1;
                end
                default: begin
                    state_d   = ST_RUN;
                    pre_cnt_d = '0;
                    per_cnt_d = '0;
                    done_d    = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            pre_cnt_q    <= '0;
            per_cnt_q    <= '0;
            period_q     <= PER_BASE;
            time_out_q   <= 1'b0;
            done_q       <= 1'b0;
            tick_count_q <= '0;
        end else begin
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            per_cnt_q    <= per_cnt_d;
            period_q     <= period_d;
            time_out_q   <= time_out_d;
            done_q       <= done_d;
            tick_count_q <= tick_count_d;
        end
    end

    assign bus.time_out   = time_out_q;
    assign bus.done       = done_q;
    assign bus.period_cur = period_q;
    assign bus.tick_count = tick_count_q;

endmodule

// File: tb/tb_variable_tick_gen.sv
// Randomised and directed bench for variable_tick_gen against an enabled-edge-count reference model.
module tb_variable_tick_gen;

    localparam int PRESCALE    = 4;
    localparam int BASE_PERIOD = 10;
    localparam int STEP        = 2;
    localparam int MIN_PERIOD  = 3;
    localparam int SPEED_W     = 4;
    localparam int PERIOD_W    = 16;
    localparam int CNT_W       = 3;

    logic clock;
    logic reset;

    variable_tick_gen_if #(.SPEED_W(SPEED_W), .PERIOD_W(PERIOD_W), .CNT_W(CNT_W)) bus ();

    variable_tick_gen #(
        .PRESCALE(PRESCALE), .BASE_PERIOD(BASE_PERIOD), .STEP(STEP), .MIN_PERIOD(MIN_PERIOD),
        .SPEED_W(SPEED_W), .PERIOD_W(PERIOD_W), .CNT_W(CNT_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model: enabled edges elapsed in the current period, period in force, pulse count.
    int edges_m;
    int per_m;
    int tick_m;
    bit done_m;
    bit to_m;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int calc_period(input int spd);
        int prod;
        prod = spd * STEP;
        if (prod > BASE_PERIOD - MIN_PERIOD) return MIN_PERIOD;
        return BASE_PERIOD - prod;
    endfunction

    task automatic model_reset();
        edges_m = 0;
        per_m   = BASE_PERIOD;
        tick_m  = 0;
        done_m  = 1'b0;
        to_m    = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".time_out"},   32'(bus.time_out),   32'(to_m));
        check_val({tag, ".done"},       32'(bus.done),       32'(done_m));
        check_val({tag, ".period_cur"}, 32'(bus.period_cur), 32'(per_m));
        check_val({tag, ".tick_count"}, 32'(bus.tick_count), 32'(tick_m));
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        to_m = 1'b0;
        if (!reset) begin
            model_reset();
        end else if (bus.restart) begin
            edges_m = 0;
            per_m   = calc_period(int'(bus.speed));
            done_m  = 1'b0;
        end else if (!done_m && bus.enable) begin
            edges_m++;
            if (edges_m == PRESCALE * per_m) begin
                edges_m = 0;
                to_m    = 1'b1;
                tick_m  = (tick_m + 1) % (1 << CNT_W);
                per_m   = calc_period(int'(bus.speed));
                if (bus.one_shot) done_m = 1'b1;
            end
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic do_restart(input int spd);
        bus.speed   = SPEED_W'(spd);
        bus.restart = 1'b1;
        step("restart");
        bus.restart = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        bus.enable   = 1'b0;
        bus.restart  = 1'b0;
        bus.one_shot = 1'b0;
        bus.speed    = '0;
        model_reset();

        // 1: reset, then free-running at speed 0
        run(3, "reset");
        reset      = 1'b1;
        bus.enable = 1'b1;
        run(125, "t1");
        check_val("t1.three_pulses", 32'(bus.tick_count), 32'd3);

        // 2: speed changes via restart and mid-period
        do_restart(2);
        check_val("t2.period6", 32'(bus.period_cur), 32'd6);
        run(10, "t2a");
        bus.speed = 4'd4;
        run(14, "t2b");
        check_val("t2.clamped", 32'(bus.period_cur), 32'd3);
        run(30, "t2c");
        do_restart(15);
        check_val("t2.period3", 32'(bus.period_cur), 32'd3);
        run(30, "t2d");

        // 3: pause mid-period
        do_restart(0);
        run(9, "t3a");
        bus.enable = 1'b0;
        run(7, "t3pause");
        bus.enable = 1'b1;
        run(40, "t3b");

        // 4: one-shot
        do_restart(0);
        bus.one_shot = 1'b1;
        run(40, "t4a");
        check_val("t4.done", 32'(bus.done), 32'd1);
        run(200, "t4hold");
        bus.one_shot = 1'b0;
        do_restart(0);
        check_val("t4.cleared", 32'(bus.done), 32'd0);
        run(45, "t4b");

        // 5: restart coinciding with terminal count, then counter wrap
        for (int i = 0; i < 100 && edges_m != PRESCALE * per_m - 1; i++) step("t5seek");
        check_val("t5.aligned", 32'(edges_m), 32'(PRESCALE * per_m - 1));
        do_restart(0);
        check_val("t5.no_pulse", 32'(bus.time_out), 32'd0);
        run(8 * 40 + 5, "t5wrap");

        // 6: asynchronous reset between edges
        run(7, "t6pre");
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs("t6async");
        run(2, "t6held");
        #3;
        reset = 1'b1;

        // Randomised phase
        for (int i = 0; i < 4000; i++) begin
            bus.enable   = ($urandom_range(0, 9) != 0);
            bus.restart  = ($urandom_range(0, 299) == 0);
            bus.one_shot = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 49) == 0) bus.speed = SPEED_W'($urandom_range(0, 15));
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
